// File: rtl/rasterizer_pkg.sv
// Shared types and constants for the depth test unit.
package rasterizer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        READY = 2'd2
    } dtu_state_t;

    // Largest positive signed depth: farther than any fragment.
    localparam logic [15:0] DEPTH_CLEAR = 16'h7FFF;

endpackage

// File: rtl/depth_ram.sv
// Depth buffer: 1 write + 1 read port, read-first, one-cycle read latency.
// Owns the clear address counter and the write-port mux.
import rasterizer_pkg::*;

module depth_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 19200,
    parameter int AW    = 15
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear_en,
    output logic             clear_last,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data
);

    localparam logic [AW-1:0]    LAST_ADDR  = AW'(DEPTH - 1);
    localparam logic [WIDTH-1:0] CLEAR_WORD = WIDTH'(DEPTH_CLEAR);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rd_data_r;
    logic [AW-1:0]    clr_cnt_r;

    assign clear_last = clear_en & (clr_cnt_r == LAST_ADDR);
    assign rd_data    = rd_data_r;

    // Clear address counter: sweeps 0..DEPTH-1 while clearing, parked at 0 otherwise.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            clr_cnt_r <= {AW{1'b0}};
        end else if (clear_en && (clr_cnt_r != LAST_ADDR)) begin
            clr_cnt_r <= clr_cnt_r + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            clr_cnt_r <= {AW{1'b0}};
        end
    end

    // Storage: clear owns the port; a fragment write landing in the first clear
    // cycle is dropped because the sweep overwrites every entry anyway.
    always_ff @(posedge clk) begin
        if (rstn) begin
            if (clear_en) begin
                mem_r[clr_cnt_r] <= CLEAR_WORD;
            end else if (wr_en) begin
                mem_r[wr_addr] <= wr_data;
            end
        end
        rd_data_r <= mem_r[rd_addr];
    end

endmodule

// File: rtl/depth_test_unit.sv
// Z-test stage: read-compare-write against the depth buffer, emits colour write
// strobes for fragments nearer than the stored depth, and clears between frames.
import rasterizer_pkg::*;

module depth_test_unit #(
    parameter int DEPTH_WIDTH   = 16,
    parameter int FB_ADDR_WIDTH = 15,
    parameter int FB_SIZE       = 19200,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clear_start,
    output logic                     clear_busy,
    input  logic                     frag_valid,
    output logic                     frag_ready,
    input  logic [FB_ADDR_WIDTH-1:0] frag_addr,
    input  logic [DEPTH_WIDTH-1:0]   frag_depth,
    input  logic                     raster_done,
    output logic                     pix_we,
    output logic [FB_ADDR_WIDTH-1:0] pix_addr,
    output logic [DEPTH_WIDTH-1:0]   pix_depth,
    output logic [CNT_WIDTH-1:0]     pass_count,
    output logic                     done
);

    localparam logic [FB_ADDR_WIDTH-1:0] ADDR_LIMIT = FB_ADDR_WIDTH'(FB_SIZE);

    dtu_state_t state_r, next_state_s;

    logic                     accept_s, in_range_s, clear_entry_s, clear_last_s;
    logic [FB_ADDR_WIDTH-1:0] rd_addr_s;
    logic [DEPTH_WIDTH-1:0]   rd_data_s, stored_s;
    logic                     pass_s, drained_s;

    logic                     s1_valid_r, s1_occ_r, out_occ_r;
    logic [FB_ADDR_WIDTH-1:0] s1_addr_r, byp_addr_r, pix_addr_r;
    logic [DEPTH_WIDTH-1:0]   s1_depth_r, byp_depth_r, pix_depth_r;
    logic                     byp_valid_r, pix_we_r, done_r;
    logic [CNT_WIDTH-1:0]     pass_count_r;

    assign frag_ready = (state_r == READY);
    assign clear_busy = (state_r == CLEAR);
    assign accept_s   = frag_valid & frag_ready;
    assign in_range_s = (frag_addr < ADDR_LIMIT);
    assign rd_addr_s  = in_range_s ? frag_addr : {FB_ADDR_WIDTH{1'b0}};

    // The RAM is read-first, so the write committed one cycle ago is invisible
    // to this read; forward it to keep same-address fragments serialised.
    assign stored_s  = (byp_valid_r && (byp_addr_r == s1_addr_r)) ? byp_depth_r : rd_data_s;
    assign pass_s    = s1_valid_r && ($signed(s1_depth_r) < $signed(stored_s));
    assign drained_s = !accept_s && !s1_occ_r && !out_occ_r;

    assign pix_we     = pix_we_r;
    assign pix_addr   = pix_addr_r;
    assign pix_depth  = pix_depth_r;
    assign pass_count = pass_count_r;
    assign done       = done_r;

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; a clear request while clearing is ignored.
    always_comb begin
        next_state_s  = state_r;
        clear_entry_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (clear_start) begin
                    next_state_s  = CLEAR;
                    clear_entry_s = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            CLEAR: begin
                if (clear_last_s) begin
                    next_state_s = READY;
                end else begin
                    next_state_s = CLEAR;
                end
            end
            READY: begin
                if (clear_start) begin
                    next_state_s  = CLEAR;
                    clear_entry_s = 1'b1;
                end else begin
                    next_state_s = READY;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Fragment pipeline: S0 -> S1 registers, bypass of the last committed write.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid_r  <= 1'b0;
            s1_occ_r    <= 1'b0;
            out_occ_r   <= 1'b0;
            s1_addr_r   <= {FB_ADDR_WIDTH{1'b0}};
            s1_depth_r  <= {DEPTH_WIDTH{1'b0}};
            byp_valid_r <= 1'b0;
            byp_addr_r  <= {FB_ADDR_WIDTH{1'b0}};
            byp_depth_r <= {DEPTH_WIDTH{1'b0}};
        end else begin
            s1_valid_r  <= accept_s & in_range_s;
            s1_occ_r    <= accept_s;
            out_occ_r   <= s1_occ_r;
            s1_addr_r   <= frag_addr;
            s1_depth_r  <= frag_depth;
            byp_valid_r <= pass_s;
            byp_addr_r  <= s1_addr_r;
            byp_depth_r <= s1_depth_r;
        end
    end

    // Colour write strobe and saturating pass counter.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pix_we_r     <= 1'b0;
            pix_addr_r   <= {FB_ADDR_WIDTH{1'b0}};
            pix_depth_r  <= {DEPTH_WIDTH{1'b0}};
            pass_count_r <= {CNT_WIDTH{1'b0}};
        end else begin
            pix_we_r <= pass_s;
            if (pass_s) begin
                pix_addr_r  <= s1_addr_r;
                pix_depth_r <= s1_depth_r;
            end else begin
                pix_addr_r  <= pix_addr_r;
                pix_depth_r <= pix_depth_r;
            end
            if (clear_entry_s) begin
                pass_count_r <= {CNT_WIDTH{1'b0}};
            end else if (pass_s && (pass_count_r != {CNT_WIDTH{1'b1}})) begin
                pass_count_r <= pass_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                pass_count_r <= pass_count_r;
            end
        end
    end

    // Triangle retired once the rasterizer is finished and every stage is empty.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            done_r <= 1'b0;
        end else if (!raster_done || clear_start) begin
            done_r <= 1'b0;
        end else if (drained_s) begin
            done_r <= 1'b1;
        end else begin
            done_r <= done_r;
        end
    end

    depth_ram #(
        .WIDTH (DEPTH_WIDTH),
        .DEPTH (FB_SIZE),
        .AW    (FB_ADDR_WIDTH)
    ) u_depth_ram (
        .clk        (clk),
        .rstn       (rstn),
        .clear_en   (state_r == CLEAR),
        .clear_last (clear_last_s),
        .rd_addr    (rd_addr_s),
        .rd_data    (rd_data_s),
        .wr_en      (pass_s),
        .wr_addr    (s1_addr_r),
        .wr_data    (s1_depth_r)
    );

endmodule

// File: tb/tb_depth_test_unit.sv
// Scoreboard bench for depth_test_unit: a serialised depth-array model predicts
// every colour write; a monitor checks each pix_we against the expectation queue.
module tb_depth_test_unit;

    localparam int FB_SIZE = 19200;

    logic               clk = 1'b0;
    logic               rstn, clear_start, frag_valid, raster_done;
    logic [14:0]        frag_addr;
    logic signed [15:0] frag_depth;
    logic               clear_busy, frag_ready, pix_we, done;
    logic [14:0]        pix_addr;
    logic signed [15:0] pix_depth;
    logic [15:0]        pass_count;

    typedef struct {
        int                 cyc;
        logic [14:0]        a;
        logic signed [15:0] d;
    } exp_t;

    exp_t               q[$];
    logic signed [15:0] model [FB_SIZE];
    int                 cyc = 0;
    int                 n_vec = 0;
    int                 n_fail = 0;
    int                 exp_cnt = 0;
    int                 last_send = 0;

    depth_test_unit dut (
        .clk         (clk),
        .rstn        (rstn),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .frag_valid  (frag_valid),
        .frag_ready  (frag_ready),
        .frag_addr   (frag_addr),
        .frag_depth  (frag_depth),
        .raster_done (raster_done),
        .pix_we      (pix_we),
        .pix_addr    (pix_addr),
        .pix_depth   (pix_depth),
        .pass_count  (pass_count),
        .done        (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Reference: fragments resolve in arrival order against the depth array.
    task automatic model_frag(input logic [14:0] a, input logic signed [15:0] d);
        exp_t e;
        if (int'(a) < FB_SIZE) begin
            if (d < model[a]) begin
                model[a] = d;
                e.cyc = cyc + 2;
                e.a   = a;
                e.d   = d;
                q.push_back(e);
            end
        end
    endtask

    task automatic send(input logic [14:0] a, input logic signed [15:0] d, input bit track);
        @(posedge clk);
        #1;
        frag_valid = 1'b1;
        frag_addr  = a;
        frag_depth = d;
        last_send  = cyc;
        if (track) model_frag(a, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            frag_valid = 1'b0;
        end
    endtask

    task automatic run_clear(input bit with_frag, input logic [14:0] a, input logic signed [15:0] d);
        int n;
        @(posedge clk);
        #1;
        clear_start = 1'b1;
        exp_cnt     = 0;
        if (with_frag) begin
            frag_valid = 1'b1;
            frag_addr  = a;
            frag_depth = d;
            model_frag(a, d);
        end
        for (int i = 0; i < FB_SIZE; i++) model[i] = 16'sh7FFF;
        @(posedge clk);
        #1;
        clear_start = 1'b0;
        frag_valid  = 1'b0;
        n = 0;
        for (int i = 0; i < FB_SIZE + 50; i++) begin
            @(negedge clk);
            if (clear_busy === 1'b1) begin
                n++;
                if (n == 1) check("ready_low_in_clear", frag_ready, 0);
            end else begin
                break;
            end
        end
        check("clear_cycles", n, FB_SIZE);
        check("ready_after_clear", frag_ready, 1);
        check("count_after_clear", pass_count, exp_cnt);
    endtask

    // Monitor: every strobe must match the oldest predicted pass, on time.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (pix_we === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_pix_we", 1, 0);
            end else begin
                e = q.pop_front();
                check("pix_addr", pix_addr, e.a);
                check("pix_depth", pix_depth, e.d);
                check("pix_cycle", cyc, e.cyc);
                exp_cnt++;
                check("pass_count", pass_count, exp_cnt);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [14:0]        a;
        logic signed [15:0] d;
        int                 r, lat;
        rstn = 1'b0; clear_start = 1'b0; frag_valid = 1'b0; raster_done = 1'b0;
        frag_addr = 15'd0; frag_depth = 16'sd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_clear_busy", clear_busy, 0);
        check("rst_frag_ready", frag_ready, 0);
        check("rst_pix_we", pix_we, 0);
        check("rst_pix_addr", pix_addr, 0);
        check("rst_pix_depth", pix_depth, 0);
        check("rst_pass_count", pass_count, 0);
        check("rst_done", done, 0);
        @(posedge clk);
        #1 rstn = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_not_ready", frag_ready, 0);

        run_clear(1'b0, 15'd0, 16'sd0);

        // Directed: clear value at both ends, equal/greater/nearer, back-to-back, out of range.
        send(15'd0, 16'sh7FFF, 1'b1);
        send(15'd0, 16'sh7FFE, 1'b1);
        send(15'd19199, 16'sh7FFE, 1'b1);
        send(15'd5, 16'sd100, 1'b1);
        send(15'd5, 16'sd200, 1'b1);
        send(15'd5, 16'sd100, 1'b1);
        send(15'd5, -16'sd3, 1'b1);
        send(15'd7, 16'sd50, 1'b1);
        send(15'd7, 16'sd60, 1'b1);
        send(15'd7, 16'sd40, 1'b1);
        send(15'd19200, 16'sd10, 1'b1);
        send(15'd32767, -16'sd1, 1'b1);
        send(15'd0, 16'sd20, 1'b1);
        idle(4);

        // Random traffic concentrated on a few addresses to stress the bypass.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                r = $urandom_range(0, 19);
                if (r < 17)       a = 15'(r);
                else if (r == 17) a = 15'd19199;
                else              a = 15'($urandom_range(19200, 32767));
                if ($urandom_range(0, 9) == 0) d = 16'($urandom_range(0, 65535));
                else                           d = 16'(int'($urandom_range(0, 600)) - 300);
                send(a, d, 1'b1);
            end else begin
                idle(1);
            end
        end
        idle(6);

        // done after the last fragment drains.
        send(15'd3, -16'sd32000, 1'b1);
        raster_done = 1'b1;
        idle(1);
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = cyc - last_send;
                break;
            end
        end
        check("done_latency_min", (lat >= 2), 1);
        check("done_latency_max", (lat <= 8), 1);
        @(posedge clk);
        #1 raster_done = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("done_drops", done, 0);
        idle(3);

        // Clear requested with a passing fragment in flight, then the cleared value must win.
        run_clear(1'b1, 15'd5, -16'sd7);
        send(15'd5, -16'sd6, 1'b1);
        idle(5);

        // Reset with a passing fragment in flight: no strobe may follow.
        send(15'd9, -16'sd30000, 1'b0);
        @(posedge clk);
        #1;
        frag_valid = 1'b0;
        rstn       = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        exp_cnt = 0;
        repeat (4) @(negedge clk);
        check("rst_pipe_pix_we", pix_we, 0);
        check("rst_pipe_count", pass_count, 0);
        check("rst_pipe_ready", frag_ready, 0);

        // Reset 100 cycles into a clear.
        @(posedge clk);
        #1 clear_start = 1'b1;
        @(posedge clk);
        #1 clear_start = 1'b0;
        repeat (99) @(posedge clk);
        #1 rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_clear_busy", clear_busy, 0);
        check("rst_mid_clear_ready", frag_ready, 0);
        #1 rstn = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle_busy", clear_busy, 0);
        check("post_rst_idle_ready", frag_ready, 0);

        check("queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
